// File: rtl/kernel_nios2_cpu_mul_unit.sv
// rtl/kernel_nios2_cpu_mul_unit.sv - two-stage pipelined slice multiplier with signed/unsigned operands
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   E_src1, E_src2      operands (DATA_W)
//   E_valid             operands valid this cycle
//   E_sign1, E_sign2    treat the matching operand as two's complement
//   E_hi                select the upper half of the 2*DATA_W product
//   M_en                pipeline advance enable (0 = every register holds)
//   M_flush             kill all in-flight operations
//   M_result            selected product half, registered
//   M_valid             M_result is valid
//   M_busy              an operation is in stage 1 or stage 2
module kernel_nios2_cpu_mul_unit #(
    parameter int DATA_W         = 32,
    parameter int SLICE_W        = 16,
    parameter int SIGNED_SUPPORT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic              E_valid,
    input  logic              E_sign1,
    input  logic              E_sign2,
    input  logic              E_hi,
    input  logic              M_en,
    input  logic              M_flush,
    output logic [DATA_W-1:0] M_result,
    output logic              M_valid,
    output logic              M_busy
);

    localparam int N   = DATA_W / SLICE_W;
    localparam int NP  = N * N;
    localparam int PPW = 2 * SLICE_W;
    localparam int PW  = 2 * DATA_W;

    logic             sign1_eff;
    logic             sign2_eff;
    logic [PPW-1:0]   pp_next [NP];
    logic [PW-1:0]    corr_next;

    logic             s1_valid;
    logic             s1_hi;
    logic [PPW-1:0]   s1_pp [NP];
    logic [PW-1:0]    s1_corr;

    logic [PW-1:0]    sum;

    assign sign1_eff = (SIGNED_SUPPORT != 0) && E_sign1;
    assign sign2_eff = (SIGNED_SUPPORT != 0) && E_sign2;

    // Unsigned slice products, plus the two's complement fix-up: a negative
    // operand weighs -2^DATA_W more than its unsigned reading, so the other
    // operand shifted by DATA_W is subtracted once per negative operand.
    // The +2^(2*DATA_W) cross term vanishes modulo the product width.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pp_next[i*N+j] = PPW'(E_src1[i*SLICE_W +: SLICE_W])
                               * PPW'(E_src2[j*SLICE_W +: SLICE_W]);
            end
        end
        corr_next = '0;
        if (sign1_eff && E_src1[DATA_W-1]) begin
            corr_next = corr_next - {E_src2, {DATA_W{1'b0}}};
        end
        if (sign2_eff && E_src2[DATA_W-1]) begin
            corr_next = corr_next - {E_src1, {DATA_W{1'b0}}};
        end
    end

    // Stage 1: valid tag obeys flush first; data only loads for valid ops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_hi    <= 1'b0;
            s1_corr  <= '0;
            for (int k = 0; k < NP; k++) begin
                s1_pp[k] <= '0;
            end
        end else begin
            if (M_flush) begin
                s1_valid <= 1'b0;
            end else if (M_en) begin
                s1_valid <= E_valid;
            end
            if (M_en && E_valid) begin
                s1_hi   <= E_hi;
                s1_corr <= corr_next;
                for (int k = 0; k < NP; k++) begin
                    s1_pp[k] <= pp_next[k];
                end
            end
        end
    end

    // Partial products placed at slice weight i+j, accumulated mod 2^PW.
    always_comb begin
        sum = s1_corr;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = sum + (PW'(s1_pp[i*N+j]) << (SLICE_W * (i + j)));
            end
        end
    end

    // Stage 2: result register and its valid tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            M_valid  <= 1'b0;
            M_result <= '0;
        end else begin
            if (M_flush) begin
                M_valid <= 1'b0;
            end else if (M_en) begin
                M_valid <= s1_valid;
            end
            if (M_en && s1_valid) begin
                M_result <= s1_hi ? sum[PW-1:DATA_W] : sum[DATA_W-1:0];
            end
        end
    end

    assign M_busy = s1_valid | M_valid;

endmodule

// File: doc/kernel_nios2_cpu_mul_unit.md
Name: kernel_nios2_cpu_mul_unit

Overview:
Parametrised, pipelined integer multiplier for the Nios II execute/memory stages. It computes the full 2*DATA_W-bit product of two operands from SLICE_W x SLICE_W partial products, which are summed in-block. Each operand is independently signed or unsigned, and the block returns either the low or the high half of the product. The M-stage enable stalls the pipeline, a flush clears it, and valid tags travel with the data.

Parameters:
DATA_W, 32, operand and result width; must be a multiple of SLICE_W.
SLICE_W, 16, partial-product slice width; DATA_W/SLICE_W must be 1, 2 or 4.
SIGNED_SUPPORT, 1, 1 = E_sign1/E_sign2 are honoured; 0 = both operands are treated as unsigned and the sign inputs are ignored.

Ports:
clk  in  1  single clock; all registers on the rising edge
reset_n  in  1  asynchronous active-low reset
E_src1  in  DATA_W  operand A
E_src2  in  DATA_W  operand B
E_valid  in  1  operands valid this cycle
E_sign1  in  1  1 = E_src1 is two's complement
E_sign2  in  1  1 = E_src2 is two's complement
E_hi  in  1  1 = return product[2*DATA_W-1:DATA_W]; 0 = return product[DATA_W-1:0]
M_en  in  1  pipeline advance enable; 0 = all stages hold
M_flush  in  1  kill all in-flight operations
M_result  out  DATA_W  selected product half, registered
M_valid  out  1  M_result is valid
M_busy  out  1  at least one operation is in flight (stage-1 or stage-2 valid)

Behaviour:
- Reset (reset_n=0, asynchronous): all pipeline registers clear. M_result=0, M_valid=0, M_busy=0.
- Stage 1 register (advances only when M_en=1):
  - Captures the valid bit (E_valid), E_hi, and all (DATA_W/SLICE_W)^2 unsigned slice products.
  - Also captures the sign-correction terms: if sign1 and E_src1[MSB], subtract E_src2 shifted by DATA_W; symmetric term for sign2 and E_src2[MSB].
- Stage 2 register (advances only when M_en=1):
  - Sums the shifted partial products plus the correction terms, modulo 2^(2*DATA_W).
  - Selects the half chosen by the stage-1 E_hi and loads it into M_result. M_valid takes the stage-1 valid bit.
- Latency: exactly 2 cycles in which M_en=1. Throughput: one operation per enabled cycle; back-to-back issue is supported.
- M_en=0: every register holds, including M_result and M_valid. Input changes during a stall have no effect.
- M_flush=1 at an edge: both stage valid bits clear, regardless of M_en. Flush has priority over advance, and the operand presented in the same cycle is dropped. M_result data is don't-care after a flush; M_valid=0.
- M_busy = stage-1 valid OR stage-2 valid. This is combinational from registers only.
- An invalid operation (E_valid=0) may still load data registers; only the valid bits are architecturally significant. For power, data registers may be gated on E_valid.
- DATA_W/SLICE_W=1: single product, no summation; the stage-2 register still exists (latency unchanged).
- Reset mid-operation: all in-flight results are discarded. The first valid output after reset comes 2 enabled cycles after the first accepted E_valid.
- Arithmetic result equals (sext_or_zext(A) * sext_or_zext(B)) mod 2^(2*DATA_W), with the extension per sign bit. This covers mul, mulxss, mulxuu, and mulxsu.
- No combinational path exists from inputs to outputs.

Test Plan:
- Unsigned, DATA_W=32: A=B=0xFFFFFFFF, M_en=1. E_hi=0 gives 0x00000001 two cycles later with M_valid=1; E_hi=1 gives 0xFFFFFFFE.
- Signed both: A=B=0x80000000, E_hi=1 gives 0x40000000 and E_hi=0 gives 0x00000000. A=B=0xFFFFFFFF with E_hi=1 gives 0x00000000.
- Mixed sign (sign1=1, sign2=0): A=0xFFFFFFFF, B=0xFFFFFFFF, E_hi=1 gives 0xFFFFFFFF; E_hi=0 gives 0x00000001.
- Stall and back-to-back: issue 3 ops on consecutive cycles (3*5, 7*9, 0x10000*0x10000 with E_hi=1), then drop M_en for 4 cycles after the first result. Required outputs are 15, 63, 0x00000001, in order. M_result and M_valid are frozen during the stall, and M_busy=1 until the last result is out.
- Flush: issue 2 ops, then assert M_flush with M_en=0 and a new E_valid op. M_valid stays 0, M_busy=0 on the next cycle, and no result emerges.
- Reset mid-operation plus parameter sweep: drop reset_n asynchronously between clock edges with 2 ops in flight. M_valid=0 and M_result=0 immediately. Also repeat 1,000 random signed/unsigned ops against a reference model for DATA_W/SLICE_W of 32/32, 32/16 and 64/16.
